// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing with pixel-rate enable, shadowed config,
// delayed sync/display flags and a line-fetch request handshake.
module video_timing_gen #(
    parameter int CW       = 16,
    parameter int FREQ_W   = 8,
    parameter int REF_FREQ = 125,
    parameter int DELAY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FREQ_W-1:0] pxl_freq,
    input  logic              hsync_pol,
    input  logic              vsync_pol,
    input  logic [CW-1:0]     h_total,
    input  logic [CW-1:0]     h_end_disp,
    input  logic [CW-1:0]     h_srt_sync,
    input  logic [CW-1:0]     h_end_sync,
    input  logic [CW-1:0]     v_total,
    input  logic [CW-1:0]     v_end_disp,
    input  logic [CW-1:0]     v_srt_sync,
    input  logic [CW-1:0]     v_end_sync,
    input  logic [CW-1:0]     fb_width,
    input  logic [CW-1:0]     fb_height,
    input  logic              cfg_load,
    output logic              pxl_en,
    output logic [CW-1:0]     h_count,
    output logic [CW-1:0]     v_count,
    output logic              hsync,
    output logic              vsync,
    output logic              de,
    output logic              fb_en,
    output logic              line_req,
    output logic [CW-1:0]     line_idx,
    input  logic              line_ack,
    output logic              frame_irq,
    output logic              underrun
);
    localparam int NC = 10 * CW + 2;

    logic [FREQ_W:0]   acc;
    logic [FREQ_W+1:0] sum;
    logic [NC-1:0]     cfg, cfg_in;
    logic              cfg_pending;
    logic              hp, vp;
    logic [CW-1:0]     ht, hd, hs0, hs1, vt, vd, vs0, vs1, fw, fh;
    logic              h_last, v_last, eof, req_pt;
    logic [3:0]        st;
    logic [3:0]        pipe [0:DELAY];

    assign sum    = {1'b0, acc} + {2'b0, pxl_freq};
    assign cfg_in = {hsync_pol, vsync_pol, h_total, h_end_disp, h_srt_sync, h_end_sync,
                     v_total, v_end_disp, v_srt_sync, v_end_sync, fb_width, fb_height};
    assign {hp, vp, ht, hd, hs0, hs1, vt, vd, vs0, vs1, fw, fh} = cfg;

    assign h_last = h_count == ht - CW'(1);
    assign v_last = v_count == vt - CW'(1);
    assign eof    = pxl_en && h_last && v_last;
    assign req_pt = enable && pxl_en && h_count == '0 && (v_last || v_count + CW'(1) < fh);

    always_comb begin
        st[3] = (h_count >= hs0 && h_count < hs1) ^ hp;
        st[2] = (v_count >= vs0 && v_count < vs1) ^ vp;
        st[1] = h_count < hd && v_count < vd;
        st[0] = st[1] && h_count < fw && v_count < fh;
    end

    assign {hsync, vsync, de, fb_en} = pipe[DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            pxl_en <= 1'b0;
        end else begin
            pxl_en <= sum >= (FREQ_W+2)'(REF_FREQ);
            acc    <= sum >= (FREQ_W+2)'(REF_FREQ) ? (FREQ_W+1)'(sum - (FREQ_W+2)'(REF_FREQ))
                                                   : sum[FREQ_W:0];
        end
    end

    // Config changes while running are deferred to the frame boundary to avoid torn frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg         <= '0;
            cfg_pending <= 1'b0;
        end else if (!enable) begin
            cfg         <= cfg_in;
            cfg_pending <= 1'b0;
        end else begin
            if (eof && (cfg_pending || cfg_load)) cfg <= cfg_in;
            cfg_pending <= eof ? 1'b0 : cfg_pending || cfg_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_count <= '0;
            v_count <= '0;
        end else if (!enable) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pxl_en) begin
            h_count <= h_last ? '0 : h_count + CW'(1);
            if (h_last) v_count <= v_last ? '0 : v_count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || !enable) begin
            for (int i = 0; i <= DELAY; i++) pipe[i] <= '0;
        end else if (pxl_en) begin
            pipe[0] <= st;
            for (int i = 1; i <= DELAY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // A new request point overrides an unacknowledged one and flags the lost fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_req  <= 1'b0;
            line_idx  <= '0;
            underrun  <= 1'b0;
            frame_irq <= 1'b0;
        end else if (!enable) begin
            line_req  <= 1'b0;
            line_idx  <= '0;
            underrun  <= 1'b0;
            frame_irq <= 1'b0;
        end else begin
            frame_irq <= pxl_en && h_last && v_count == vd - CW'(1);
            underrun  <= req_pt && line_req && !line_ack;
            if (req_pt) begin
                line_req <= 1'b1;
                line_idx <= v_last ? '0 : v_count + CW'(1);
            end else if (line_ack) begin
                line_req <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized configurations checked cycle by cycle against a
// position-arithmetic reference model, plus directed rate, shadow and reset checks.
module tb_video_timing_gen;
    localparam int CW = 16;
    localparam int D  = 1;

    logic          clk = 0, rst = 1, enable = 0, cfg_load = 0, line_ack = 0;
    logic [7:0]    pxl_freq = 0;
    logic          hsync_pol = 0, vsync_pol = 0;
    logic [CW-1:0] h_total = 0, h_end_disp = 0, h_srt_sync = 0, h_end_sync = 0;
    logic [CW-1:0] v_total = 0, v_end_disp = 0, v_srt_sync = 0, v_end_sync = 0;
    logic [CW-1:0] fb_width = 0, fb_height = 0;
    logic          pxl_en, hsync, vsync, de, fb_en, line_req, frame_irq, underrun;
    logic [CW-1:0] h_count, v_count, line_idx;

    video_timing_gen #(.CW(CW), .FREQ_W(8), .REF_FREQ(125), .DELAY(D)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pxl_freq(pxl_freq),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol),
        .h_total(h_total), .h_end_disp(h_end_disp), .h_srt_sync(h_srt_sync), .h_end_sync(h_end_sync),
        .v_total(v_total), .v_end_disp(v_end_disp), .v_srt_sync(v_srt_sync), .v_end_sync(v_end_sync),
        .fb_width(fb_width), .fb_height(fb_height), .cfg_load(cfg_load),
        .pxl_en(pxl_en), .h_count(h_count), .v_count(v_count),
        .hsync(hsync), .vsync(vsync), .de(de), .fb_en(fb_en),
        .line_req(line_req), .line_idx(line_idx), .line_ack(line_ack),
        .frame_irq(frame_irq), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_acc, m_pen, n, m_lreq, m_idx, m_irq, m_und;
    int ht, hd, hs0, hs1, vt, vd, vs0, vs1, fw, fh, hp, vp;
    bit cmp = 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] flags(input int q);
        int h, v;
        logic a, b, dd, f;
        h  = q % ht;
        v  = (q / ht) % vt;
        a  = (h >= hs0 && h < hs1) ^ hp[0];
        b  = (v >= vs0 && v < vs1) ^ vp[0];
        dd = h < hd && v < vd;
        f  = dd && h < fw && v < fh;
        return {a, b, dd, f};
    endfunction

    // Model: n counts pixel ticks since enable; raster position is n folded by the totals.
    task automatic step();
        int h, v, s;
        bit rp;
        if (rst) begin
            m_acc = 0; m_pen = 0; n = 0; m_lreq = 0; m_idx = 0; m_irq = 0; m_und = 0;
            return;
        end
        if (!enable) begin
            ht = h_total; hd = h_end_disp; hs0 = h_srt_sync; hs1 = h_end_sync;
            vt = v_total; vd = v_end_disp; vs0 = v_srt_sync; vs1 = v_end_sync;
            fw = fb_width; fh = fb_height; hp = hsync_pol; vp = vsync_pol;
            n = 0; m_lreq = 0; m_idx = 0; m_irq = 0; m_und = 0;
        end else begin
            h = n % ht;
            v = (n / ht) % vt;
            rp = m_pen != 0 && h == 0 && (v == vt - 1 || v + 1 < fh);
            m_irq = (m_pen != 0 && h == ht - 1 && v == vd - 1) ? 1 : 0;
            if (rp) begin
                m_und = (m_lreq != 0 && !line_ack) ? 1 : 0;
                m_lreq = 1;
                m_idx = (v == vt - 1) ? 0 : v + 1;
            end else begin
                m_und = 0;
                if (m_lreq != 0 && line_ack) m_lreq = 0;
            end
            if (m_pen != 0) n++;
        end
        s = m_acc + pxl_freq;
        if (s >= 125) begin m_acc = (s - 125) % 512; m_pen = 1; end
        else begin m_acc = s; m_pen = 0; end
    endtask

    task automatic compare_all();
        logic [3:0] ef;
        ef = (enable && n >= 1 + D) ? flags(n - 1 - D) : 4'b0;
        chk("pxl_en", 32'(pxl_en), 32'(m_pen));
        chk("h_count", 32'(h_count), enable ? 32'(n % ht) : 32'd0);
        chk("v_count", 32'(v_count), enable ? 32'((n / ht) % vt) : 32'd0);
        chk("hs_vs_de_fb", 32'({hsync, vsync, de, fb_en}), 32'(ef));
        chk("line_req", 32'(line_req), 32'(m_lreq));
        chk("line_idx", 32'(line_idx), 32'(m_idx));
        chk("frame_irq", 32'(frame_irq), 32'(m_irq));
        chk("underrun", 32'(underrun), 32'(m_und));
    endtask

    task automatic cyc();
        @(posedge clk);
        step();
        @(negedge clk);
        if (cmp) compare_all();
    endtask

    task automatic rand_cfg();
        h_total    = 16'($urandom_range(8, 20));
        h_end_disp = 16'($urandom_range(1, h_total - 2));
        h_srt_sync = 16'($urandom_range(h_end_disp, h_total - 1));
        h_end_sync = 16'($urandom_range(h_srt_sync + 1, h_total));
        v_total    = 16'($urandom_range(4, 10));
        v_end_disp = 16'($urandom_range(1, v_total - 1));
        v_srt_sync = 16'($urandom_range(v_end_disp, v_total - 1));
        v_end_sync = 16'($urandom_range(v_srt_sync + 1, v_total));
        fb_width   = 16'($urandom_range(0, h_total));
        fb_height  = 16'($urandom_range(2, v_total));
        hsync_pol  = 1'($urandom);
        vsync_pol  = 1'($urandom);
        pxl_freq   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(125, 140)) : 8'($urandom_range(1, 124));
    endtask

    initial begin
        int cnt, mode, len, maxa, maxb, phase, t;
        bit done;
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_lreq", 32'(line_req), 32'd0);
        chk("rst_pxl_en", 32'(pxl_en), 32'd0);
        rst = 0;
        pxl_freq = 25; cnt = 0;
        for (int i = 0; i < 50; i++) begin cyc(); cnt += int'(pxl_en); end
        chk("rate25", 32'(cnt), 32'd10);
        pxl_freq = 0; cnt = 0;
        for (int i = 0; i < 50; i++) begin cyc(); cnt += int'(pxl_en); end
        chk("rate0", 32'(cnt), 32'd0);

        for (int r = 0; r < 20; r++) begin
            enable = 0;
            rand_cfg();
            mode = $urandom_range(0, 2);
            cyc(); cyc();
            enable = 1;
            len = $urandom_range(300, 700);
            for (int i = 0; i < len; i++) begin
                line_ack = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom);
                cyc();
            end
            enable = 0;
            cyc(); cyc();
        end

        // Shadow update: a mid-frame load must not take effect until the frame wraps.
        h_total = 10; h_end_disp = 8; h_srt_sync = 8; h_end_sync = 9;
        v_total = 6; v_end_disp = 4; v_srt_sync = 4; v_end_sync = 5;
        fb_width = 10; fb_height = 6; pxl_freq = 125; line_ack = 1;
        cyc(); cyc();
        enable = 1; cmp = 0;
        t = 0;
        while (v_count != 2 && t < 200) begin cyc(); t++; end
        h_total = 14; cfg_load = 1;
        cyc();
        cfg_load = 0;
        maxa = 0; maxb = 0; phase = 0; done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            cyc();
            if (phase == 0 && v_count == 0) phase = 1;
            if (phase == 1 && v_count == 1) done = 1;
            if (phase == 0 && int'(h_count) > maxa) maxa = h_count;
            if (phase == 1 && v_count == 0 && int'(h_count) > maxb) maxb = h_count;
        end
        chk("shadow_done", 32'(done), 32'd1);
        chk("len_old", 32'(maxa), 32'd9);
        chk("len_new", 32'(maxb), 32'd13);
        enable = 0; h_total = 10;
        cyc(); cyc();
        cmp = 1;

        // Reset mid-line, then re-enable: the frame restarts and line 1 is fetched first.
        enable = 1; line_ack = 0;
        for (int i = 0; i < 37; i++) cyc();
        rst = 1;
        cyc();
        chk("rst_h", 32'(h_count), 32'd0);
        chk("rst_sync", 32'({hsync, vsync, de, fb_en}), 32'd0);
        rst = 0; enable = 0;
        cyc();
        enable = 1;
        t = 0;
        while (!line_req && t < 100) begin cyc(); t++; end
        chk("first_req_seen", 32'(line_req), 32'd1);
        chk("first_idx", 32'(line_idx), 32'd1);
        for (int i = 0; i < 30; i++) cyc();
        enable = 0;
        cyc();
        chk("dis_lreq", 32'(line_req), 32'd0);
        chk("dis_v", 32'(v_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
